// File: rtl/scope_pkg.sv
// Shared types and defaults for the scope capture slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package scope_pkg;

  localparam int SAMPLE_W        = 8;
  localparam int DEF_DEPTH       = 256;
  localparam int DEF_ADDR_BITS   = 8;
  localparam int DEF_PRETRIG     = 64;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRETRIG,
    ST_WAIT_TRIG,
    ST_POSTTRIG,
    ST_READOUT
  } state_t;

endpackage

// File: rtl/scope_sample_ram.sv
// Circular sample store: one write port, one registered read port (maps to iCE40 BRAM).
// Latency: read data appears one iCLK after rd_addr is presented.
// Backpressure: none; reads and writes are accepted every cycle.
module scope_sample_ram
  import scope_pkg::*;
#(
  parameter int pDepth    = DEF_DEPTH,
  parameter int pAddrBits = DEF_ADDR_BITS
) (
  input  logic                 iCLK,
  input  logic                 wr_en,
  input  logic [pAddrBits-1:0] wr_addr,
  input  logic [SAMPLE_W-1:0]  wr_data,
  input  logic [pAddrBits-1:0] rd_addr,
  output logic [SAMPLE_W-1:0]  rd_data
);

  logic [SAMPLE_W-1:0] mem [pDepth];

  // Array has no reset so the tools can place it in block RAM.
  always_ff @(posedge iCLK) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/scope_capture.sv
// Records ADC samples into a circular buffer around a level-crossing trigger, then streams the record oldest first.
// Latency: first oRd_Valid two iCLK after entering READOUT; then one beat per cycle.
// Backpressure: iRd_Ready low holds oRd_Data/oRd_Last; a skid register keeps full rate when it returns.
module scope_capture
  import scope_pkg::*;
#(
  parameter int pDepth    = DEF_DEPTH,
  parameter int pAddrBits = DEF_ADDR_BITS,
  parameter int pPreTrig  = DEF_PRETRIG
) (
  input  logic                iCLK,
  input  logic                iRST_n,
  input  logic                iSample_Strobe,
  input  logic [SAMPLE_W-1:0] iADC_Byte,
  input  logic                iArm,
  input  logic                iForce_Trig,
  input  logic [SAMPLE_W-1:0] iTrig_Level,
  input  logic                iTrig_Rising,
  output logic [SAMPLE_W-1:0] oRd_Data,
  output logic                oRd_Valid,
  input  logic                iRd_Ready,
  output logic                oRd_Last,
  output logic                oBusy,
  output logic                oTriggered
);

  localparam int CW = pAddrBits + 1;
  localparam logic [CW-1:0]        PRE_LAST  = CW'(pPreTrig - 1);
  localparam logic [CW-1:0]        POST_LAST = CW'(pDepth - pPreTrig - 1);
  localparam logic [CW-1:0]        RD_LAST   = CW'(pDepth - 1);
  localparam logic [CW-1:0]        RD_END    = CW'(pDepth);
  localparam logic [pAddrBits-1:0] PRE_OFS   = pAddrBits'(pPreTrig);

  state_t                 state, state_nxt;
  logic [pAddrBits-1:0]   wptr, tptr, rd_addr;
  logic [CW-1:0]          cnt, rd_cnt;
  logic [SAMPLE_W-1:0]    prev, ram_rd;
  logic                   prev_vld, triggered;
  logic                   arm_hit, wr_en, level_hit, trig_hit, force_hit, pre_done;

  logic [SAMPLE_W-1:0]    out_dat, skid_dat;
  logic                   out_vld, out_last, skid_vld, skid_last, pend, pend_last;
  logic                   pop, out_free, issue;
  logic [1:0]             occ_after;

  // Crossing test against the previous sample; only meaningful once a sample has been seen.
  always_comb begin
    level_hit = 1'b0;
    if (prev_vld) begin
      if (iTrig_Rising) level_hit = (prev <  iTrig_Level) && (iADC_Byte >= iTrig_Level);
      else              level_hit = (prev >= iTrig_Level) && (iADC_Byte <  iTrig_Level);
    end
  end

  // Next-state and per-cycle capture controls.
  always_comb begin
    state_nxt = state;
    arm_hit   = 1'b0;
    wr_en     = 1'b0;
    trig_hit  = 1'b0;
    force_hit = 1'b0;
    pre_done  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (iArm) begin
          arm_hit   = 1'b1;
          state_nxt = ST_PRETRIG;
        end
      end
      ST_PRETRIG: begin
        if (iSample_Strobe) begin
          wr_en = 1'b1;
          if (cnt == PRE_LAST) begin
            pre_done  = 1'b1;
            state_nxt = ST_WAIT_TRIG;
          end
        end
      end
      ST_WAIT_TRIG: begin
        if (iSample_Strobe) begin
          wr_en = 1'b1;
          if (level_hit || iForce_Trig) begin
            trig_hit  = 1'b1;
            // The trigger sample is post-sample #1; with a one-sample window it also completes it.
            state_nxt = (POST_LAST == '0) ? ST_READOUT : ST_POSTTRIG;
          end
        end else if (iForce_Trig) begin
          force_hit = 1'b1;
          state_nxt = ST_POSTTRIG;
        end
      end
      ST_POSTTRIG: begin
        if (iSample_Strobe) begin
          wr_en = 1'b1;
          if (cnt == POST_LAST) state_nxt = ST_READOUT;
        end
      end
      ST_READOUT: begin
        if (pop && out_last) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State register and capture-side bookkeeping (pointers, counters, previous sample).
  always_ff @(posedge iCLK) begin
    if (!iRST_n) begin
      state     <= ST_IDLE;
      wptr      <= '0;
      tptr      <= '0;
      cnt       <= '0;
      prev      <= '0;
      prev_vld  <= 1'b0;
      triggered <= 1'b0;
    end else begin
      state <= state_nxt;
      if (arm_hit) begin
        wptr      <= '0;
        cnt       <= '0;
        prev_vld  <= 1'b0;
        triggered <= 1'b0;
      end
      if (wr_en) begin
        wptr     <= wptr + 1'b1;
        cnt      <= cnt + 1'b1;
        prev     <= iADC_Byte;
        prev_vld <= 1'b1;
      end
      if (pre_done) cnt <= '0;
      if (trig_hit) begin
        tptr      <= wptr;
        cnt       <= CW'(1);
        triggered <= 1'b1;
      end
      if (force_hit) begin
        tptr      <= wptr;
        cnt       <= '0;
        triggered <= 1'b1;
      end
    end
  end

  // Readout: keep at most two samples in flight/held (output + skid or output + pending read).
  assign pop       = out_vld && iRd_Ready;
  assign out_free  = !out_vld || pop;
  assign occ_after = 2'(out_vld) + 2'(skid_vld) + 2'(pend) - 2'(pop);
  assign issue     = (state == ST_READOUT) && (rd_cnt != RD_END) && (occ_after < 2'd2);
  assign rd_addr   = tptr - PRE_OFS + rd_cnt[pAddrBits-1:0];

  scope_sample_ram #(
    .pDepth    (pDepth),
    .pAddrBits (pAddrBits)
  ) u_ram (
    .iCLK    (iCLK),
    .wr_en   (wr_en),
    .wr_addr (wptr),
    .wr_data (iADC_Byte),
    .rd_addr (rd_addr),
    .rd_data (ram_rd)
  );

  // Read issue, pending-read tracking and the output/skid register pair.
  always_ff @(posedge iCLK) begin
    if (!iRST_n) begin
      rd_cnt    <= '0;
      pend      <= 1'b0;
      pend_last <= 1'b0;
      out_vld   <= 1'b0;
      out_last  <= 1'b0;
      out_dat   <= '0;
      skid_vld  <= 1'b0;
      skid_last <= 1'b0;
      skid_dat  <= '0;
    end else begin
      pend      <= issue;
      pend_last <= issue && (rd_cnt == RD_LAST);
      if (arm_hit)    rd_cnt <= '0;
      else if (issue) rd_cnt <= rd_cnt + 1'b1;
      if (out_free) begin
        if (skid_vld) begin
          out_vld   <= 1'b1;
          out_dat   <= skid_dat;
          out_last  <= skid_last;
          skid_vld  <= pend;
          skid_dat  <= ram_rd;
          skid_last <= pend_last;
        end else if (pend) begin
          out_vld  <= 1'b1;
          out_dat  <= ram_rd;
          out_last <= pend_last;
        end else begin
          out_vld  <= 1'b0;
          out_last <= 1'b0;
        end
      end else if (pend) begin
        skid_vld  <= 1'b1;
        skid_dat  <= ram_rd;
        skid_last <= pend_last;
      end
    end
  end

  assign oRd_Data   = out_dat;
  assign oRd_Valid  = out_vld;
  assign oRd_Last   = out_last;
  assign oBusy      = (state != ST_IDLE);
  assign oTriggered = triggered;

endmodule

// File: tb/tb_scope_capture.sv
// Bench for scope_capture: record contents derived from the written sample history and trigger index.
// Latency: checks first-valid timing and full-rate streaming.
// Backpressure: drives stalling ready patterns and checks data hold.
module tb_scope_capture;

  localparam int DEPTH = 16;
  localparam int PRE   = 4;
  localparam int POST  = DEPTH - PRE;

  logic       clk = 1'b0;
  logic       rst_n, strobe, arm, frc, rising, rdy;
  logic [7:0] adc, lvl;
  logic [7:0] rd_data;
  logic       rd_valid, rd_last, busy, trig;

  always #5 clk = ~clk;

  scope_capture #(
    .pDepth    (DEPTH),
    .pAddrBits (4),
    .pPreTrig  (PRE)
  ) dut (
    .iCLK           (clk),
    .iRST_n         (rst_n),
    .iSample_Strobe (strobe),
    .iADC_Byte      (adc),
    .iArm           (arm),
    .iForce_Trig    (frc),
    .iTrig_Level    (lvl),
    .iTrig_Rising   (rising),
    .oRd_Data       (rd_data),
    .oRd_Valid      (rd_valid),
    .iRd_Ready      (rdy),
    .oRd_Last       (rd_last),
    .oBusy          (busy),
    .oTriggered     (trig)
  );

  int         checks = 0;
  int         errors = 0;
  logic [7:0] written[$];
  int         trig_idx;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] gen(input int kind, input int n);
    case (kind)
      0: return 8'(n * 16);
      1: return 8'(240 - n * 16);
      2: begin
        case (n)
          0, 1, 2: return 8'h00;
          3, 4:    return 8'h90;
          5, 6:    return 8'h10;
          7:       return 8'hA0;
          default: return 8'($urandom);
        endcase
      end
      3:       return 8'h20;
      default: return 8'($urandom);
    endcase
  endfunction

  function automatic bit crossed(input logic [7:0] p, input logic [7:0] c,
                                 input logic [7:0] l, input bit r);
    if (r) return (p < l) && (c >= l);
    return (p >= l) && (c < l);
  endfunction

  task automatic do_reset();
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_valid", rd_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_triggered", trig, 0);
  endtask

  task automatic do_arm();
    @(posedge clk); #1 arm = 1'b1;
    @(posedge clk); #1 arm = 1'b0;
    @(negedge clk);
    chk("arm_busy", busy, 1);
    chk("arm_triggered", trig, 0);
  endtask

  task automatic feed(input logic [7:0] v, input bit f, input bit exp_trig, input bit last);
    @(posedge clk); #1 strobe = 1'b1; adc = v; frc = f;
    @(posedge clk); #1 strobe = 1'b0; frc = 1'b0;
    @(negedge clk);
    chk("triggered", trig, exp_trig);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("first_valid_timing", rd_valid, last);
    @(posedge clk);
  endtask

  task automatic pulse_force();
    @(posedge clk); #1 frc = 1'b1;
    @(posedge clk); #1 frc = 1'b0;
    @(negedge clk);
    chk("force_triggered", trig, 1);
    chk("force_busy", busy, 1);
  endtask

  // force_at: sample index at which a force is applied (-1 none); with_strobe picks coincident vs alone.
  task automatic capture(input int kind, input bit rise, input logic [7:0] level,
                         input int force_at, input bit with_strobe, input int abort_post);
    int n;
    logic [7:0] v, prev;
    bit hit, done, is_last, abort, f;
    written.delete();
    trig_idx = -1;
    rising = rise;
    lvl = level;
    prev = 8'h00;
    do_arm();
    n = 0;
    done = 0;
    while (!done) begin
      if (force_at == n && !with_strobe && trig_idx < 0 && n >= PRE) begin
        pulse_force();
        trig_idx = n;
      end
      v = gen(kind, n);
      f = with_strobe && (force_at == n);
      hit = (trig_idx < 0) && (n >= PRE) && (f || crossed(prev, v, level, rise));
      if (hit) trig_idx = n;
      written.push_back(v);
      prev = v;
      is_last = (trig_idx >= 0) && (n + 1 == trig_idx + POST);
      abort = (abort_post >= 0) && (trig_idx >= 0) && (n + 1 == trig_idx + abort_post);
      feed(v, f, trig_idx >= 0, is_last);
      n++;
      if (is_last) done = 1;
      else if (abort) begin
        do_reset();
        done = 1;
      end else if (n >= 120) begin
        chk("trigger_within_budget", 0, 1);
        do_reset();
        done = 1;
      end
    end
  endtask

  // rmode: 0 ready held high, 1 ready pattern 1,0,0,1, 2 random ready. abort_at: beats before reset (-1 none).
  task automatic readout(input int rmode, input int abort_at);
    int beat, cyc, first, lastcyc;
    bit stalled, r, held_l;
    logic [7:0] held_d, exp_v;
    beat = 0; cyc = 0; first = -1; lastcyc = -1;
    stalled = 0; held_d = 8'h00; held_l = 0;
    while (beat < DEPTH && cyc < 400 && beat != abort_at) begin
      @(posedge clk); #1;
      case (rmode)
        0:       r = 1'b1;
        1:       r = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: r = 1'($urandom_range(0, 1));
      endcase
      rdy    = r;
      strobe = (cyc % 5 == 2);
      adc    = 8'($urandom);
      arm    = (cyc == 3);
      @(negedge clk);
      if (stalled) begin
        chk("hold_valid", rd_valid, 1);
        chk("hold_data", rd_data, held_d);
        chk("hold_last", rd_last, held_l);
      end
      stalled = 0;
      if (rd_valid) begin
        if (r) begin
          exp_v = (trig_idx >= PRE) ? written[trig_idx - PRE + beat] : 8'h00;
          chk("beat_data", rd_data, exp_v);
          chk("beat_last", rd_last, beat == DEPTH - 1);
          if (first < 0) first = cyc;
          lastcyc = cyc;
          beat++;
        end else begin
          stalled = 1;
          held_d = rd_data;
          held_l = rd_last;
        end
      end
      cyc++;
    end
    @(posedge clk); #1 strobe = 1'b0; arm = 1'b0; rdy = 1'b0;
    if (abort_at >= 0) begin
      do_reset();
    end else begin
      @(negedge clk);
      chk("beat_count", beat, DEPTH);
      chk("done_busy", busy, 0);
      chk("done_valid", rd_valid, 0);
      if (rmode == 0) chk("burst_cycles", lastcyc - first, DEPTH - 1);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; strobe = 1'b0; arm = 1'b0; frc = 1'b0; rising = 1'b1;
    rdy = 1'b0; adc = 8'h00; lvl = 8'h80;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("reset_valid", rd_valid, 0);
    chk("reset_last", rd_last, 0);
    chk("reset_busy", busy, 0);
    chk("reset_triggered", trig, 0);
    chk("reset_data", rd_data, 0);

    // Rising ramp, full-rate drain.
    capture(0, 1'b1, 8'h80, -1, 1'b0, -1);
    readout(0, -1);
    // Falling ramp, stalling consumer.
    capture(1, 1'b0, 8'h80, -1, 1'b0, -1);
    readout(1, -1);
    // Crossing inside the pre-trigger window must be ignored.
    capture(2, 1'b1, 8'h80, -1, 1'b0, -1);
    readout(2, -1);
    // Flat input, forced trigger between strobes.
    capture(3, 1'b1, 8'h80, 10, 1'b0, -1);
    readout(0, -1);
    // Reset in the post-trigger window, then in the middle of readout.
    capture(0, 1'b1, 8'h80, -1, 1'b0, 3);
    capture(1, 1'b0, 8'h80, -1, 1'b0, -1);
    readout(1, 5);
    // Fresh captures with random data, thresholds and edges.
    capture(0, 1'b1, 8'h80, -1, 1'b0, -1);
    readout(2, -1);
    capture(4, 1'b1, 8'h80, 6, 1'b1, -1);
    readout(1, -1);
    for (int k = 0; k < 4; k++) begin
      capture(4, 1'($urandom_range(0, 1)), 8'($urandom_range(64, 192)), -1, 1'b0, -1);
      readout(k % 3, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
